block_sum_coder: RTL and testbench
==================================

Name: block_sum_coder

Overview:
Parametrised successor to the two-block pixel-sum coder. It accumulates pixel values over a grid of NUM_BLK_X rectangular blocks, each BLK_W pixels wide and BLK_H lines high. At every block-row boundary it snapshots all block sums and streams them out as bytes over a valid/ready handshake. Single clock domain: frame/line strobes and pixel data are sampled on pclk, with an optional saturating-sum mode and overflow reporting. It sits between the pixel capture front end and the byte-wide host link.

Parameters:
PIX_W, 8, pixel width in bits
SUM_W, 16, per-block sum width in bits; must be a multiple of 8
BLK_W, 3, pixels per block horizontally; must be >= 1
BLK_H, 3, lines per block vertically; must be >= 1
NUM_BLK_X, 2, blocks per line; must be >= 1
SAT, 0, 1 = saturating sums, 0 = wrap modulo 2^SUM_W

Ports:
pclk  in  1  clock; all logic on rising edge
rst_n  in  1  synchronous active-low reset
vsync  in  1  one-cycle frame-start strobe
hsync  in  1  one-cycle line-start strobe
din_valid  in  1  pixel qualifier
din  in  PIX_W  pixel value
dout  out  8  output byte
dout_valid  out  1  dout holds a valid byte
dout_ready  in  1  sink accepts the byte when high with dout_valid
dout_last  out  1  marks the final byte of a block-row record
overflow  out  1  sticky: a snapshot was dropped
busy  out  1  the serializer holds unsent bytes

Behaviour:
- Reset (rst_n=0 at an edge): all counters, accumulators and the snapshot buffer are cleared. dout=0, dout_valid=0, dout_last=0, overflow=0, busy=0. Reset also aborts an in-progress record.
- Counters:
  - col_idx: 0..BLK_W-1
  - blk_idx: 0..NUM_BLK_X-1
  - row_idx: 0..BLK_H-1
  - line_done flag
- vsync: clears col_idx, blk_idx, row_idx, line_done, all accumulators and overflow. It does NOT abort the serializer. vsync has priority over hsync in the same cycle.
- hsync: clears col_idx, blk_idx and line_done. Accumulators and row_idx are kept, so a mid-line hsync restarts column counting only.
- Pixel acceptance: a pixel is accepted on an edge with din_valid=1 and line_done=0. A pixel arriving in the same cycle as vsync/hsync is accepted as column 0 of block 0, after the clear.
- On acceptance, acc[blk_idx] is updated to acc + zero-extended din.
  - SAT=1: the result clamps to 2^SUM_W-1.
  - SAT=0: the result wraps.
- Column advance: col_idx increments. At BLK_W-1 it wraps to 0 and blk_idx increments.
- End of line: at the last column of block NUM_BLK_X-1, line_done is set (further pixels on that line are ignored) and row_idx increments.
- Block-row complete: when the last accepted pixel of the line finishes row BLK_H-1, row_idx returns to 0. In the same edge:
  - All accumulators are copied to the snapshot buffer, with the final pixel included via bypass.
  - All accumulators are cleared.
- Latency: dout_valid rises in the cycle after the final pixel's edge.
- Serializer order: block 0 first, each sum MSB byte first. A record is NUM_BLK_X*SUM_W/8 bytes, with dout_last high on the final byte.
- Handshake:
  - A byte transfers on an edge with dout_valid && dout_ready.
  - dout and dout_last hold stable while dout_valid=1 and dout_ready=0.
  - After the last transfer, dout_valid drops unless a new snapshot loads on the same edge.
- busy = dout_valid.
- Snapshot collision:
  - If a snapshot fires while bytes remain, the new snapshot is discarded, overflow is set and the current record continues untouched.
  - If the last byte transfers on the same edge as the snapshot, the new snapshot is accepted with no overflow, and dout_valid stays high.

Decomposition:
- Shared package block_sum_pkg holds:
  - the BYTES_PER_SUM = SUM_W/8 constant
  - the record-length constant
  - the saturating-add function, parametrised by SUM_W
- One sub-module, sum_serializer, contains:
  - the snapshot buffer
  - the byte index counter
  - the valid/ready/last logic
  - the collision and overflow detection
- block_sum_coder keeps the counters and the accumulator array.

Test Plan:
1. Defaults; vsync, then 3 lines of 6 pixels each, pixel value = col+line+1, dout_ready=1 -> bytes 00 1B 00 36, dout_last on 0x36, first dout_valid in the cycle after the 18th pixel.
2. SUM_W=8, all pixels 0xFF for one block-row -> SAT=1 gives FF FF; SAT=0 gives F7 F7.
3. dout_ready toggled 1-0-0-1 during record 1 -> no byte duplicated or skipped; dout holds while ready=0; sequence is still 00 1B 00 36.
4. dout_ready=0 held through completion of a second block-row -> overflow=1; after release only the 4 bytes of record 1 are emitted; the next vsync clears overflow.
5. Extra pixels after column 5, plus hsync mid-line after 2 pixels -> extra pixels ignored; the 2 pre-hsync pixels stay in block 0's sum; the record closes only after 3 complete lines.
6. rst_n=0 for one cycle after byte 2 of a record -> dout_valid=0, overflow=0 next cycle; a fresh frame reproduces scenario 1.

Source files
------------

// File: rtl/block_sum_pkg.sv
// Shared definitions for the block-sum coder.
//   MAX_SUM_W      : widest accumulator the helper arithmetic supports
//   bytes_per_sum  : bytes emitted per block sum (sum width / 8)
//   record_bytes   : bytes in one block-row record
//   sat_add        : add with either saturation or wrap at a given width
package block_sum_pkg;

    localparam int MAX_SUM_W = 64;

    function automatic int bytes_per_sum(input int sum_w);
        return sum_w / 8;
    endfunction

    function automatic int record_bytes(input int sum_w, input int num_blk_x);
        return bytes_per_sum(sum_w) * num_blk_x;
    endfunction

    // Both operands are zero-extended to MAX_SUM_W. The add is done one
    // bit wider so a carry out of sum_w bits is visible for clamping.
    function automatic logic [MAX_SUM_W-1:0] sat_add(
        input logic [MAX_SUM_W-1:0] a,
        input logic [MAX_SUM_W-1:0] b,
        input int                   sum_w,
        input logic                 sat
    );
        logic [MAX_SUM_W:0] full;
        logic [MAX_SUM_W:0] limit;
        full  = {1'b0, a} + {1'b0, b};
        limit = ({{MAX_SUM_W{1'b0}}, 1'b1} << sum_w) - 1'b1;
        if (sat && (full > limit)) begin
            return limit[MAX_SUM_W-1:0];
        end
        return full[MAX_SUM_W-1:0] & limit[MAX_SUM_W-1:0];
    endfunction

endpackage

// File: rtl/block_sum_coder_if.sv
// Byte-wide output stream of the block-sum coder.
//   dout       : output byte
//   dout_valid : dout holds a valid byte
//   dout_ready : sink accepts the byte when high together with dout_valid
//   dout_last  : final byte of a block-row record
// master = coder side, slave = host-link side.
interface block_sum_coder_if;
    logic [7:0] dout;
    logic       dout_valid;
    logic       dout_ready;
    logic       dout_last;

    modport master (output dout, output dout_valid, output dout_last, input dout_ready);
    modport slave  (input dout, input dout_valid, input dout_last, output dout_ready);
endinterface

// File: rtl/sum_serializer.sv
// Snapshot buffer and byte serializer for block-row records.
//   pclk, rst_n : clock, synchronous active-low reset
//   snap_valid  : a completed block row is offered this cycle
//   snap_data   : all block sums, block 0 in the most significant position
//   ovf_clr     : clear the sticky overflow flag (frame start)
//   dout_if     : byte stream (master)
//   overflow    : sticky, a snapshot was discarded
//   busy        : bytes remain to be sent
module sum_serializer
    import block_sum_pkg::*;
#(
    parameter int SUM_W     = 16,
    parameter int NUM_BLK_X = 2
) (
    input  logic                       pclk,
    input  logic                       rst_n,
    input  logic                       snap_valid,
    input  logic [NUM_BLK_X*SUM_W-1:0] snap_data,
    input  logic                       ovf_clr,
    block_sum_coder_if.master          dout_if,
    output logic                       overflow,
    output logic                       busy
);

    localparam int BYTES_PER_SUM = bytes_per_sum(SUM_W);
    localparam int REC_BYTES     = BYTES_PER_SUM * NUM_BLK_X;
    localparam int IW            = (REC_BYTES > 1) ? $clog2(REC_BYTES) : 1;
    localparam int BUF_W         = NUM_BLK_X * SUM_W;

    logic [BUF_W-1:0] snap_buf_reg;
    logic [IW-1:0]    idx_reg;
    logic             valid_reg;
    logic             last_reg;
    logic             ovf_reg;

    logic xfer;
    logic load;
    logic collide;

    assign xfer    = valid_reg & dout_if.dout_ready;
    // A new snapshot is taken when idle, or when the final byte of the
    // current record leaves on this very edge; otherwise it is dropped.
    assign load    = snap_valid & (~valid_reg | (xfer & last_reg));
    assign collide = snap_valid & ~load;

    always_ff @(posedge pclk) begin
        if (!rst_n) begin
            snap_buf_reg <= '0;
            idx_reg      <= '0;
            valid_reg    <= 1'b0;
            last_reg     <= 1'b0;
            ovf_reg      <= 1'b0;
        end else begin
            ovf_reg <= collide | (ovf_reg & ~ovf_clr);
            if (load) begin
                snap_buf_reg <= snap_data;
                idx_reg      <= '0;
                valid_reg    <= 1'b1;
                last_reg     <= (REC_BYTES == 1);
            end else if (xfer) begin
                // The buffer shifts so the byte on dout is always the top byte.
                snap_buf_reg <= snap_buf_reg << 8;
                if (last_reg) begin
                    valid_reg <= 1'b0;
                    last_reg  <= 1'b0;
                    idx_reg   <= '0;
                end else begin
                    idx_reg  <= idx_reg + 1'b1;
                    last_reg <= (idx_reg == IW'(REC_BYTES - 2));
                end
            end
        end
    end

    assign dout_if.dout       = snap_buf_reg[BUF_W-1 -: 8];
    assign dout_if.dout_valid = valid_reg;
    assign dout_if.dout_last  = last_reg;
    assign overflow           = ovf_reg;
    assign busy               = valid_reg;

endmodule

// File: rtl/block_sum_coder.sv
// Accumulates pixel sums over a row of NUM_BLK_X blocks (BLK_W x BLK_H each)
// and, at each block-row boundary, hands all sums to the serializer which
// streams them out MSB byte first, block 0 first.
//   pclk, rst_n        : clock, synchronous active-low reset
//   vsync, hsync       : one-cycle frame / line start strobes
//   din_valid, din     : pixel qualifier and value
//   dout_if            : byte stream (master)
//   overflow           : sticky, a snapshot was dropped (cleared by vsync)
//   busy               : serializer holds unsent bytes
module block_sum_coder
    import block_sum_pkg::*;
#(
    parameter int PIX_W     = 8,
    parameter int SUM_W     = 16,
    parameter int BLK_W     = 3,
    parameter int BLK_H     = 3,
    parameter int NUM_BLK_X = 2,
    parameter int SAT       = 0
) (
    input  logic             pclk,
    input  logic             rst_n,
    input  logic             vsync,
    input  logic             hsync,
    input  logic             din_valid,
    input  logic [PIX_W-1:0] din,
    block_sum_coder_if.master dout_if,
    output logic             overflow,
    output logic             busy
);

    localparam int CW = (BLK_W > 1)     ? $clog2(BLK_W)     : 1;
    localparam int BW = (NUM_BLK_X > 1) ? $clog2(NUM_BLK_X) : 1;
    localparam int RW = (BLK_H > 1)     ? $clog2(BLK_H)     : 1;

    logic [CW-1:0] col_idx_reg, col_idx_next, col_eff;
    logic [BW-1:0] blk_idx_reg, blk_idx_next, blk_eff;
    logic [RW-1:0] row_idx_reg, row_idx_next, row_eff;
    logic          line_done_reg, line_done_next, line_done_eff;

    logic [NUM_BLK_X-1:0][SUM_W-1:0] acc_reg;
    logic [NUM_BLK_X-1:0][SUM_W-1:0] merged;
    logic [NUM_BLK_X*SUM_W-1:0]      snap_data;
    logic [SUM_W-1:0]                acc_sel;
    logic [SUM_W-1:0]                new_sum;

    logic clr_line;
    logic accept;
    logic row_done;

    // Strobes clear state before the pixel of the same cycle is applied, so
    // everything below works on these "effective" values.
    assign clr_line      = vsync | hsync;
    assign col_eff       = clr_line ? '0 : col_idx_reg;
    assign blk_eff       = clr_line ? '0 : blk_idx_reg;
    assign line_done_eff = clr_line ? 1'b0 : line_done_reg;
    assign row_eff       = vsync ? '0 : row_idx_reg;
    assign accept        = din_valid & ~line_done_eff;

    // One shared adder: pick the accumulator of the current block.
    always_comb begin
        acc_sel = '0;
        for (int i = 0; i < NUM_BLK_X; i++) begin
            if (blk_eff == BW'(i)) begin
                acc_sel = acc_reg[i];
            end
        end
        if (vsync) begin
            acc_sel = '0;
        end
    end

    assign new_sum = SUM_W'(sat_add(MAX_SUM_W'(acc_sel), MAX_SUM_W'(din), SUM_W, SAT != 0));

    // merged holds every accumulator with this cycle's pixel folded in; it
    // is both the next accumulator value and the snapshot (bypass of the
    // final pixel). Block 0 goes to the top of the snapshot word.
    for (genvar gi = 0; gi < NUM_BLK_X; gi++) begin : g_blk
        assign merged[gi] = (accept && (blk_eff == BW'(gi))) ? new_sum
                          : (vsync ? '0 : acc_reg[gi]);
        assign snap_data[(NUM_BLK_X-1-gi)*SUM_W +: SUM_W] = merged[gi];
    end

    always_comb begin
        col_idx_next   = col_eff;
        blk_idx_next   = blk_eff;
        row_idx_next   = row_eff;
        line_done_next = line_done_eff;
        row_done       = 1'b0;
        if (accept) begin
            if (col_eff == CW'(BLK_W - 1)) begin
                col_idx_next = '0;
                if (blk_eff == BW'(NUM_BLK_X - 1)) begin
                    // Last pixel of the line: lock out further pixels.
                    blk_idx_next   = '0;
                    line_done_next = 1'b1;
                    if (row_eff == RW'(BLK_H - 1)) begin
                        row_idx_next = '0;
                        row_done     = 1'b1;
                    end else begin
                        row_idx_next = row_eff + 1'b1;
                    end
                end else begin
                    blk_idx_next = blk_eff + 1'b1;
                end
            end else begin
                col_idx_next = col_eff + 1'b1;
            end
        end
    end

    always_ff @(posedge pclk) begin
        if (!rst_n) begin
            col_idx_reg   <= '0;
            blk_idx_reg   <= '0;
            row_idx_reg   <= '0;
            line_done_reg <= 1'b0;
            acc_reg       <= '0;
        end else begin
            col_idx_reg   <= col_idx_next;
            blk_idx_reg   <= blk_idx_next;
            row_idx_reg   <= row_idx_next;
            line_done_reg <= line_done_next;
            acc_reg       <= row_done ? '0 : merged;
        end
    end

    sum_serializer #(
        .SUM_W     (SUM_W),
        .NUM_BLK_X (NUM_BLK_X)
    ) u_ser (
        .pclk       (pclk),
        .rst_n      (rst_n),
        .snap_valid (row_done),
        .snap_data  (snap_data),
        .ovf_clr    (vsync),
        .dout_if    (dout_if),
        .overflow   (overflow),
        .busy       (busy)
    );

endmodule

// File: tb/tb_block_sum_coder.sv
// Directed bench: main coder with defaults, plus two SUM_W=8 coders
// (saturating and wrapping) sharing the pixel stimulus. Expected bytes are
// queued at stimulus time and popped by monitors on each transfer.
module tb_block_sum_coder;

    logic       pclk = 1'b0;
    logic       rst_n = 1'b0;
    logic       vsync = 1'b0;
    logic       hsync = 1'b0;
    logic       din_valid = 1'b0;
    logic [7:0] din = 8'h00;
    logic       overflow, busy, ovf_s, busy_s, ovf_w, busy_w;

    block_sum_coder_if bif ();
    block_sum_coder_if sif ();
    block_sum_coder_if wif ();

    block_sum_coder u_dut (
        .pclk(pclk), .rst_n(rst_n), .vsync(vsync), .hsync(hsync),
        .din_valid(din_valid), .din(din), .dout_if(bif),
        .overflow(overflow), .busy(busy)
    );

    block_sum_coder #(.SUM_W(8), .SAT(1)) u_sat (
        .pclk(pclk), .rst_n(rst_n), .vsync(vsync), .hsync(hsync),
        .din_valid(din_valid), .din(din), .dout_if(sif),
        .overflow(ovf_s), .busy(busy_s)
    );

    block_sum_coder #(.SUM_W(8), .SAT(0)) u_wrap (
        .pclk(pclk), .rst_n(rst_n), .vsync(vsync), .hsync(hsync),
        .din_valid(din_valid), .din(din), .dout_if(wif),
        .overflow(ovf_w), .busy(busy_w)
    );

    always #5 pclk = ~pclk;

    int         n_checks = 0;
    int         n_fail = 0;
    int         xfer_cnt = 0;
    bit         chk_small = 1'b0;
    logic [8:0] exp_q[$];
    logic [8:0] sat_q[$];
    logic [8:0] wrap_q[$];

    task automatic check(input string name, input int act, input int req);
        n_checks++;
        if (act != req) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
        end
    endtask

    task automatic unexpected(input string name, input int act);
        n_checks++;
        n_fail++;
        $display("FAIL %s: got byte 0x%0h, expected none", name, act);
    endtask

    // Main stream monitor: scoreboard pop on transfer, stability while stalled.
    logic [8:0] hold_val;
    bit         hold_pending = 1'b0;
    always @(negedge pclk) begin
        logic [8:0] got;
        got = {bif.dout_last, bif.dout};
        if (rst_n && bif.dout_valid) begin
            if (hold_pending) check("hold_while_stalled", int'(got), int'(hold_val));
            if (bif.dout_ready) begin
                xfer_cnt++;
                $display("main byte %0d: 0x%02h last=%0b", xfer_cnt, got[7:0], got[8]);
                if (exp_q.size() == 0) unexpected("main_unexpected", int'(got));
                else check("main_byte", int'(got), int'(exp_q.pop_front()));
                hold_pending = 1'b0;
            end else begin
                hold_pending = 1'b1;
                hold_val     = got;
            end
        end else begin
            hold_pending = 1'b0;
        end
    end

    // Narrow-sum monitors; their sinks are always ready.
    always @(negedge pclk) begin
        if (chk_small && rst_n) begin
            if (sif.dout_valid) begin
                $display("sat byte: 0x%02h last=%0b", sif.dout, sif.dout_last);
                if (sat_q.size() == 0) unexpected("sat_unexpected", int'({sif.dout_last, sif.dout}));
                else check("sat_byte", int'({sif.dout_last, sif.dout}), int'(sat_q.pop_front()));
            end
            if (wif.dout_valid) begin
                $display("wrap byte: 0x%02h last=%0b", wif.dout, wif.dout_last);
                if (wrap_q.size() == 0) unexpected("wrap_unexpected", int'({wif.dout_last, wif.dout}));
                else check("wrap_byte", int'({wif.dout_last, wif.dout}), int'(wrap_q.pop_front()));
            end
        end
    end

    task automatic tick();
        @(posedge pclk);
        #1;
    endtask

    task automatic strobe(input bit vs, input bit hs);
        vsync = vs;
        hsync = hs;
        tick();
        vsync = 1'b0;
        hsync = 1'b0;
    endtask

    task automatic pix(input logic [7:0] v);
        din_valid = 1'b1;
        din       = v;
        tick();
        din_valid = 1'b0;
    endtask

    task automatic push_rec(input logic [31:0] r);
        exp_q.push_back({1'b0, r[31:24]});
        exp_q.push_back({1'b0, r[23:16]});
        exp_q.push_back({1'b0, r[15:8]});
        exp_q.push_back({1'b1, r[7:0]});
    endtask

    // Three lines of six pixels; value = col+line+1 unless fixed >= 0.
    task automatic block_row(input int fixed, input logic [31:0] rec,
                             input bit push, input bit chk_lat);
        logic [7:0] v;
        for (int l = 0; l < 3; l++) begin
            strobe(1'b0, 1'b1);
            for (int c = 0; c < 6; c++) begin
                v = (fixed >= 0) ? 8'(fixed) : 8'(c + l + 1);
                if (l == 2 && c == 5) begin
                    if (push) push_rec(rec);
                    if (chk_lat) begin
                        din_valid = 1'b1;
                        din       = v;
                        @(negedge pclk);
                        check("valid_before_final_pixel", int'(bif.dout_valid), 0);
                        tick();
                        din_valid = 1'b0;
                        @(negedge pclk);
                        check("valid_after_final_pixel", int'(bif.dout_valid), 1);
                    end else begin
                        pix(v);
                    end
                end else begin
                    pix(v);
                end
            end
        end
    endtask

    task automatic wait_drain(input int budget);
        int k;
        k = 0;
        while ((exp_q.size() != 0 || bif.dout_valid) && k < budget) begin
            tick();
            k++;
        end
        check("drain_within_budget", int'(exp_q.size() == 0 && !bif.dout_valid), 1);
    endtask

    initial begin
        int base;
        int k;
        bif.dout_ready = 1'b0;
        sif.dout_ready = 1'b1;
        wif.dout_ready = 1'b1;

        // Reset state
        tick();
        tick();
        check("reset_dout", int'(bif.dout), 0);
        check("reset_valid", int'(bif.dout_valid), 0);
        check("reset_last", int'(bif.dout_last), 0);
        check("reset_overflow", int'(overflow), 0);
        check("reset_busy", int'(busy), 0);
        rst_n = 1'b1;
        tick();

        // 1: basic record and latency
        bif.dout_ready = 1'b1;
        strobe(1'b1, 1'b0);
        block_row(-1, 32'h001B0036, 1'b1, 1'b1);
        wait_drain(50);

        // 2: all 0xFF; 8-bit sums saturate / wrap, 16-bit gives 0x08F7
        repeat (4) tick();
        chk_small = 1'b1;
        sat_q.push_back({1'b0, 8'hFF});
        sat_q.push_back({1'b1, 8'hFF});
        wrap_q.push_back({1'b0, 8'hF7});
        wrap_q.push_back({1'b1, 8'hF7});
        strobe(1'b1, 1'b0);
        block_row(255, 32'h08F708F7, 1'b1, 1'b0);
        wait_drain(50);
        repeat (3) tick();
        check("small_queues_empty", sat_q.size() + wrap_q.size(), 0);
        check("small_idle", int'({busy_s, busy_w, ovf_s, ovf_w}), 0);
        chk_small = 1'b0;

        // 3: ready pattern 1-0-0-1
        strobe(1'b1, 1'b0);
        block_row(-1, 32'h001B0036, 1'b1, 1'b0);
        bif.dout_ready = 1'b1;
        tick();
        bif.dout_ready = 1'b0;
        check("stall_byte", int'(bif.dout), 8'h1B);
        tick();
        tick();
        bif.dout_ready = 1'b1;
        wait_drain(50);

        // 4: second block row while stalled is dropped
        bif.dout_ready = 1'b0;
        strobe(1'b1, 1'b0);
        block_row(-1, 32'h001B0036, 1'b1, 1'b0);
        block_row(-1, 32'h0, 1'b0, 1'b0);
        check("overflow_set", int'(overflow), 1);
        check("busy_while_stalled", int'(busy), 1);
        check("first_byte_held", int'({bif.dout_last, bif.dout}), 0);
        bif.dout_ready = 1'b1;
        wait_drain(50);
        check("overflow_sticky", int'(overflow), 1);
        strobe(1'b1, 1'b0);
        check("overflow_cleared_by_vsync", int'(overflow), 0);

        // 5: mid-line hsync and extra pixels
        strobe(1'b1, 1'b0);
        strobe(1'b0, 1'b1);
        pix(8'd10);
        pix(8'd20);
        for (int l = 0; l < 3; l++) begin
            strobe(1'b0, 1'b1);
            for (int c = 0; c < 6; c++) begin
                if (l == 2 && c == 5) begin
                    push_rec(32'h0030002D);
                    check("no_early_record", int'(bif.dout_valid), 0);
                end
                pix(8'(c + 1));
            end
            repeat (3) pix(8'd100);
        end
        wait_drain(50);

        // 6: reset mid-record after two bytes, with overflow pending
        strobe(1'b1, 1'b0);
        block_row(-1, 32'h001B0036, 1'b1, 1'b0);
        base = xfer_cnt;
        k = 0;
        while (xfer_cnt < base + 2 && k < 20) begin
            tick();
            k++;
        end
        bif.dout_ready = 1'b0;
        check("two_bytes_sent", xfer_cnt - base, 2);
        block_row(-1, 32'h0, 1'b0, 1'b0);
        check("overflow_before_reset", int'(overflow), 1);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        exp_q.delete();
        check("post_reset_valid", int'(bif.dout_valid), 0);
        check("post_reset_overflow", int'(overflow), 0);
        check("post_reset_last", int'(bif.dout_last), 0);
        check("post_reset_busy", int'(busy), 0);
        bif.dout_ready = 1'b1;
        strobe(1'b1, 1'b0);
        block_row(-1, 32'h001B0036, 1'b1, 1'b1);
        wait_drain(50);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        n_checks++;
        n_fail++;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
